// File: rtl/pid_pkg.sv
// Shared types and default widths for the buck-converter PID compensator.
// The duty ceiling is expressed in the accumulator's Q.FRAC scaling.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    SAT
  } state_t;

  localparam int ERR_W  = 8;
  localparam int COEF_W = 12;
  localparam int FRAC   = 8;
  localparam int DUTY_W = 9;
  localparam int ACC_W  = 24;

  function automatic int duty_max_q(input int duty_w, input int frac);
    return ((2 ** duty_w) - 1) * (2 ** frac);
  endfunction

  localparam int DUTY_MAX_Q = duty_max_q(DUTY_W, FRAC);

endpackage

// File: rtl/pid_sat.sv
// Combinational clamp of the signed accumulator into the legal duty range
// [0, DUTY_MAX_Q], reporting which bound was hit.
module pid_sat #(
  parameter int ACC_W  = pid_pkg::ACC_W,
  parameter int DUTY_W = pid_pkg::DUTY_W,
  parameter int FRAC   = pid_pkg::FRAC
) (
  input  logic signed [ACC_W-1:0]       acc,
  output logic        [DUTY_W+FRAC-1:0] clamped,
  output logic                          sat_hi,
  output logic                          sat_lo
);
  import pid_pkg::*;

  localparam logic signed [ACC_W-1:0] MAX_Q = ACC_W'(duty_max_q(DUTY_W, FRAC));

  always_comb begin
    sat_hi  = (acc > MAX_Q);
    sat_lo  = acc[ACC_W-1];
    clamped = acc[DUTY_W+FRAC-1:0];
    if (sat_hi) begin
      clamped = MAX_Q[DUTY_W+FRAC-1:0];
    end else if (sat_lo) begin
      clamped = '0;
    end
  end

endmodule

// File: rtl/pid_compensator.sv
// Incremental PID: u[n] = u[n-1] + a*e[n] + b*e[n-1] + c*e[n-2], one shared
// multiplier stepped by the FSM, clamped result fed back as u[n-1].
module pid_compensator #(
  parameter int ERR_W  = pid_pkg::ERR_W,
  parameter int COEF_W = pid_pkg::COEF_W,
  parameter int FRAC   = pid_pkg::FRAC,
  parameter int DUTY_W = pid_pkg::DUTY_W,
  parameter int ACC_W  = pid_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [ERR_W-1:0]  adc_err,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_b,
  input  logic [COEF_W-1:0] coef_c,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  output logic              busy,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              overrun
);
  import pid_pkg::*;

  localparam int PROD_W = ERR_W + COEF_W;
  localparam int U_W    = DUTY_W + FRAC;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic        [U_W-1:0]     u_prev;
  logic signed [ERR_W-1:0]   e0, e1, e2;

  logic signed [COEF_W-1:0]  coef_sel;
  logic signed [ERR_W-1:0]   err_sel;
  logic signed [PROD_W-1:0]  product;
  logic signed [ACC_W-1:0]   acc_sum;

  logic        [U_W-1:0]     clamped;
  logic                      clamp_hi, clamp_lo;

  // Operand mux for the single shared multiplier; idle states feed zeros.
  always_comb begin
    coef_sel = '0;
    err_sel  = '0;
    case (state)
      MAC0: begin coef_sel = coef_a; err_sel = e0; end
      MAC1: begin coef_sel = coef_b; err_sel = e1; end
      MAC2: begin coef_sel = coef_c; err_sel = e2; end
      default: ;
    endcase
  end

  assign product = PROD_W'(coef_sel) * PROD_W'(err_sel);
  assign acc_sum = acc + ACC_W'(product);

  pid_sat #(
    .ACC_W  (ACC_W),
    .DUTY_W (DUTY_W),
    .FRAC   (FRAC)
  ) u_sat (
    .acc     (acc),
    .clamped (clamped),
    .sat_hi  (clamp_hi),
    .sat_lo  (clamp_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      u_prev     <= '0;
      e0         <= '0;
      e1         <= '0;
      e2         <= '0;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      busy       <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (adc_valid && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (adc_valid) begin
            e0    <= adc_err;
            acc   <= ACC_W'(u_prev);
            state <= MAC0;
            busy  <= 1'b1;
          end
        end
        MAC0: begin
          acc   <= acc_sum;
          state <= MAC1;
        end
        MAC1: begin
          acc   <= acc_sum;
          state <= MAC2;
        end
        MAC2: begin
          acc   <= acc_sum;
          state <= SAT;
        end
        SAT: begin
          // Storing the clamped value (not raw acc) is what prevents windup.
          u_prev     <= clamped;
          duty_out   <= clamped[FRAC +: DUTY_W];
          sat_hi     <= clamp_hi;
          sat_lo     <= clamp_lo;
          e2         <= e1;
          e1         <= e0;
          duty_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_compensator.sv
// Randomized bench for pid_compensator: an arithmetic reference model predicts
// every output each cycle, plus literal expectations for the directed cases.
module tb_pid_compensator;

  localparam int MAXQ = 511 * 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_valid;
  logic [7:0]  adc_err;
  logic [11:0] coef_a, coef_b, coef_c;
  logic [8:0]  duty_out;
  logic        duty_valid, busy, sat_hi, sat_lo, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  pid_compensator #(
    .ERR_W  (8),
    .COEF_W (12),
    .FRAC   (8),
    .DUTY_W (9),
    .ACC_W  (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_valid  (adc_valid),
    .adc_err    (adc_err),
    .coef_a     (coef_a),
    .coef_b     (coef_b),
    .coef_c     (coef_c),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .busy       (busy),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of samples and u kept as plain integers.
  int m_u = 0, m_e1 = 0, m_e2 = 0, m_cnt = 0;
  int p_u = 0, p_duty = 0, p_e0 = 0;
  bit p_hi = 0, p_lo = 0;
  int exp_duty = 0;
  bit exp_valid = 0, exp_busy = 0, exp_hi = 0, exp_lo = 0, exp_ovr = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_u = 0; m_e1 = 0; m_e2 = 0; m_cnt = 0;
      exp_duty = 0; exp_valid = 0; exp_busy = 0;
      exp_hi = 0; exp_lo = 0; exp_ovr = 0;
    end else begin
      exp_valid = 0;
      if (adc_valid && m_cnt != 0) exp_ovr = 1;
      if (m_cnt == 0) begin
        if (adc_valid) begin
          int e0, acc;
          e0 = int'($signed(adc_err));
          acc = m_u + int'($signed(coef_a)) * e0
                    + int'($signed(coef_b)) * m_e1
                    + int'($signed(coef_c)) * m_e2;
          p_hi = (acc > MAXQ);
          p_lo = (acc < 0);
          p_u = p_hi ? MAXQ : (p_lo ? 0 : acc);
          p_duty = p_u / 256;
          p_e0 = e0;
          m_cnt = 4;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_u = p_u;
          m_e2 = m_e1;
          m_e1 = p_e0;
          exp_duty = p_duty;
          exp_hi = p_hi;
          exp_lo = p_lo;
          exp_valid = 1;
        end
      end
      exp_busy = (m_cnt != 0);
    end
  end

  always @(negedge clk) begin
    check("duty_out",   int'(duty_out),   exp_duty);
    check("duty_valid", int'(duty_valid), int'(exp_valid));
    check("busy",       int'(busy),       int'(exp_busy));
    check("sat_hi",     int'(sat_hi),     int'(exp_hi));
    check("sat_lo",     int'(sat_lo),     int'(exp_lo));
    check("overrun",    int'(overrun),    int'(exp_ovr));
  end

  // Entered at posedge+1; pulses adc_valid for one cycle, returns `gap`
  // edges after the pulse edge, again at posedge+1.
  task automatic send(input int v, input int gap);
    adc_err   = 8'(v);
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    for (int i = 0; i < gap - 1; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic set_coefs(input int a, input int b, input int c);
    coef_a = 12'(a);
    coef_b = 12'(b);
    coef_c = 12'(c);
  endtask

  initial begin
    rst = 1'b0;
    adc_valid = 1'b0;
    adc_err = '0;
    set_coefs(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("reset_duty", int'(duty_out), 0);
    check("reset_ovr",  int'(overrun),  0);

    // Proportional accumulation.
    set_coefs(256, 0, 0);
    send(10, 6);
    check("p_first", int'(duty_out), 10);
    send(10, 6);
    check("p_second", int'(duty_out), 20);

    // Upper clamp, then recovery from the clamped u.
    do_reset();
    set_coefs(2047, 0, 0);
    send(127, 6);
    check("hi_duty", int'(duty_out), 511);
    check("hi_flag", int'(sat_hi), 1);
    set_coefs(256, 0, 0);
    send(-1, 6);
    check("hi_recover", int'(duty_out), 510);
    check("hi_cleared", int'(sat_hi), 0);

    // Lower clamp without windup.
    do_reset();
    send(-128, 6);
    check("lo_duty", int'(duty_out), 0);
    check("lo_flag", int'(sat_lo), 1);
    send(3, 6);
    check("lo_recover", int'(duty_out), 3);

    // History alignment on e[n-1] and e[n-2].
    do_reset();
    set_coefs(0, 256, 0);
    send(5, 6);
    check("b_first", int'(duty_out), 0);
    send(7, 6);
    check("b_second", int'(duty_out), 5);
    do_reset();
    set_coefs(0, 0, 256);
    send(5, 6);
    send(7, 6);
    check("c_second", int'(duty_out), 0);
    send(9, 6);
    check("c_third", int'(duty_out), 5);

    // Overrun is discarded and sticky.
    do_reset();
    set_coefs(256, 0, 0);
    send(10, 2);
    send(100, 6);
    check("ovr_duty", int'(duty_out), 10);
    check("ovr_flag", int'(overrun), 1);
    send(1, 6);
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_next", int'(duty_out), 11);

    // Reset during MAC1 aborts cleanly.
    do_reset();
    set_coefs(256, 0, 0);
    send(50, 2);
    rst = 1'b0;
    @(negedge clk);
    check("abort_duty", int'(duty_out), 0);
    check("abort_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    send(4, 6);
    check("abort_next", int'(duty_out), 4);

    // Randomized sequences with occasional overruns at various spacings.
    for (int blk = 0; blk < 12; blk++) begin
      repeat (6) @(posedge clk);
      #1;
      if (blk % 4 == 0) do_reset();
      set_coefs(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 4095)));
      for (int k = 0; k < 20; k++) begin
        int gap;
        gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 4))
                                          : int'($urandom_range(5, 8));
        send(int'($urandom_range(0, 255)), gap);
      end
    end
    repeat (8) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
